// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Iterative RV32M multiply/divide sequencer that sits beside the EX stage.
// An accepted operation is reduced to unsigned magnitudes, run through 32
// shift-add (multiply) or restoring-divide steps over one shared 64-bit
// accumulator, sign-corrected, and then presented for one cycle with `done`.
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-low reset
//   start     in   EX issues an M-extension op this cycle
//   op        in   RV32M funct3 (000 MUL .. 111 REMU)
//   src1      in   rs1 operand (multiplicand / dividend)
//   src2      in   rs2 operand (multiplier / divisor)
//   rd        in   destination register tag
//   flush     in   synchronous abort of the operation in flight
//   stallreq  out  pipeline stall request (combinational)
//   busy      out  sequencer in CALC or FIX
//   done      out  one-cycle pulse, result/rd_o valid
//   result    out  32-bit operation result
//   rd_o      out  destination tag of the completed operation
//
// Timing (start cycle = 0): CALC 1..32, FIX 33, DONE 34.
// Divide by zero skips straight to DONE in cycle 1.
// Only XLEN = 32 is supported.
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            stallreq,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int W2 = 2 * XLEN;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]      state_q,   state_d;
    logic [2:0]      op_q,      op_d;
    logic [4:0]      rd_q,      rd_d;
    logic            neg_res_q, neg_res_d;
    logic [4:0]      cnt_q,     cnt_d;
    logic [W2-1:0]   acc_q,     acc_d;     // {hi, lo}: product, or {rem, quo}
    logic [XLEN-1:0] opnd_q,    opnd_d;    // multiplicand or divisor magnitude
    logic [XLEN-1:0] result_q,  result_d;
    logic [4:0]      rd_o_q,    rd_o_d;

    // -------------------------------------------------------------------------
    // Issue-cycle operand conditioning
    // -------------------------------------------------------------------------
    logic            sign1_en, sign2_en;
    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            is_div_in;
    logic            neg_res_in;

    assign is_div_in = op[2];
    assign sign1_en  = (op == OP_MULH) || (op == OP_MULHSU) ||
                       (op == OP_DIV)  || (op == OP_REM);
    assign sign2_en  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);

    assign neg1 = sign1_en && src1[XLEN-1];
    assign neg2 = sign2_en && src2[XLEN-1];
    // Negating 0x80000000 gives 0x80000000, which is the correct unsigned
    // magnitude 2^31, so the most-negative operand needs no special case.
    assign mag1 = neg1 ? (~src1 + 1'b1) : src1;
    assign mag2 = neg2 ? (~src2 + 1'b1) : src2;

    // The remainder takes the dividend's sign; everything else the XOR.
    // Unsigned ops have both neg flags clear, so this is 0 for them.
    assign neg_res_in = (op == OP_REM) ? neg1 : (neg1 ^ neg2);

    // -------------------------------------------------------------------------
    // Iteration datapath
    // -------------------------------------------------------------------------
    logic [XLEN:0]   mul_sum;
    logic [W2-1:0]   mul_next;
    logic [XLEN+1:0] div_diff;
    logic [W2-1:0]   div_next;
    logic            unused_div_diff_b32;

    // Shift-add: low half holds the not-yet-consumed multiplier bits; the
    // carry out of the upper-half add re-enters as the new MSB on the shift.
    assign mul_sum  = {1'b0, acc_q[W2-1:XLEN]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide. The shifted remainder is 33 bits wide (the bit that
    // falls out of the 64-bit shift is rem's carry), so the trial subtract is
    // done one bit wider still and its MSB is the borrow.
    assign div_diff = {1'b0, acc_q[W2-1:XLEN-1]} - {2'b00, opnd_q};
    assign div_next = div_diff[XLEN+1]
                    ? {acc_q[W2-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    // A successful trial always leaves a difference below the divisor, so
    // bit 32 of the difference is zero by construction.
    assign unused_div_diff_b32 = div_diff[XLEN];

    // -------------------------------------------------------------------------
    // Sign correction and result select (used in FIX)
    // -------------------------------------------------------------------------
    logic [W2-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic [XLEN-1:0] fix_result;

    assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1)  : acc_q[XLEN-1:0];
    assign rem_fix  = neg_res_q ? (~acc_q[W2-1:XLEN] + 1'b1) : acc_q[W2-1:XLEN];

    always_comb begin
        fix_result = prod_fix[W2-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[W2-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            OP_REM, OP_REMU:              fix_result = rem_fix;
            default:                      fix_result = prod_fix[W2-1:XLEN];
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d is given its hold value first so no path through the
        // case below leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_res_d = neg_res_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        rd_o_d    = rd_o_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    rd_d      = rd;
                    neg_res_d = neg_res_in;
                    cnt_d     = 5'd0;
                    // The low half is preloaded with the operand that gets
                    // consumed bit by bit: multiplier for mul, dividend for div.
                    opnd_d    = is_div_in ? mag2 : mag1;
                    acc_d     = {{XLEN{1'b0}}, (is_div_in ? mag1 : mag2)};
                    if (is_div_in && (src2 == '0)) begin
                        // RISC-V divide-by-zero: quotient all ones,
                        // remainder the raw dividend.
                        result_d = op[1] ? src1 : {XLEN{1'b1}};
                        rd_o_d   = rd;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end

            S_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                result_d = fix_result;
                rd_o_d   = rd_q;
                state_d  = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins in every state and must not disturb the visible result.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            rd_o_d   = rd_o_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the accumulator and operand registers are reset along with the
    // control state so that every output reads zero while RST is low, not
    // just the FSM.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            rd_q      <= 5'd0;
            neg_res_q <= 1'b0;
            cnt_q     <= 5'd0;
            acc_q     <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            rd_o_q    <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, regardless of statement order.
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_res_q <= neg_res_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            rd_o_q    <= rd_o_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // stallreq asserts in the issue cycle so EX holds the instruction. It is
    // qualified by RST so a start held during reset cannot raise it.
    assign stallreq = RST && (((state_q == S_IDLE) && start && !flush) ||
                              (state_q == S_CALC) || (state_q == S_FIX));
    assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign rd_o     = rd_o_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Scoreboard bench for muldiv_ctrl. The driver pushes the expected result,
// tag and completion cycle for every tracked issue; an independent monitor
// pops and compares whenever `done` is seen. Expected values come from a
// plain-arithmetic RV32M model using 64-bit integers.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        CLK   = 1'b0;
    logic        RST   = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] src1  = 32'd0;
    logic [31:0] src2  = 32'd0;
    logic [4:0]  rd    = 5'd0;
    logic        flush = 1'b0;
    logic        stallreq, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_o;

    muldiv_ctrl #(.XLEN(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .rd       (rd),
        .flush    (flush),
        .stallreq (stallreq),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_o     (rd_o)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural RV32M reference.
    function automatic logic [31:0] ref_model(input logic [2:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb_, ua, ub, r;
        logic [63:0] rb;
        sa  = longint'({{32{a[31]}}, a});
        sb_ = longint'({{32{b[31]}}, b});
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        case (o)
            OP_MUL:    r = ua * ub;
            OP_MULH:   r = sa * sb_;
            OP_MULHSU: r = sa * ub;
            OP_MULHU:  r = ua * ub;
            OP_DIV:    r = (b == 0) ? -1 : sa / sb_;
            OP_DIVU:   r = (b == 0) ? -1 : ua / ub;
            OP_REM:    r = (b == 0) ? sa : sa % sb_;
            default:   r = (b == 0) ? ua : ua % ub;
        endcase
        rb = r;
        if (o == OP_MULH || o == OP_MULHSU || o == OP_MULHU) return rb[63:32];
        return rb[31:0];
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] b);
        return (o[2] && b == 32'd0) ? 1 : 34;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding issue.
    always @(negedge CLK) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 with no outstanding op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {32'd0, result}, {32'd0, e.res});
                check("rd_o", {59'd0, rd_o}, {59'd0, e.rd});
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                last_res = e.res;
            end
        end
    end

    // Call just after a posedge; returns at (cycle 1) + #1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r,
                         input bit track, output int c0);
        exp_t e;
        c0    = cyc;
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        rd    = r;
        if (track) begin
            e.res = ref_model(o, a, b);
            e.rd  = r;
            e.cyc = c0 + latency(o, b);
            sb.push_back(e);
        end
        @(negedge CLK);
        check("stall_issue", {63'd0, stallreq}, 64'd1);
        @(posedge CLK);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        src1  = $urandom;
        src2  = $urandom;
    endtask

    // Waits for done, counting stall cycles; occasionally pokes start mid-CALC
    // to confirm it is ignored.
    task automatic wait_done(input int lat, input bit poke);
        int n = 0;
        int stall_cnt = 1;
        bit seen = 0;
        while (n < 60) begin
            @(negedge CLK);
            n++;
            if (done) begin
                seen = 1;
                break;
            end
            if (stallreq) stall_cnt++;
            if (poke && n >= 3 && n <= 25 && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
                src1  = $urandom;
                src2  = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 60 cycles, expected latency %0d", lat);
        end else begin
            check("stall_in_done", {63'd0, stallreq}, 64'd0);
            check("stall_cycles", 64'(stall_cnt), 64'(lat));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input bit poke);
        int c0;
        issue(o, a, b, r, 1'b1, c0);
        wait_done(latency(o, b), poke);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c0;

        // Reset state, with start held high to show stallreq stays low.
        start = 1'b1;
        #1;
        check("rst_done",     {63'd0, done},     64'd0);
        check("rst_busy",     {63'd0, busy},     64'd0);
        check("rst_stallreq", {63'd0, stallreq}, 64'd0);
        check("rst_result",   {32'd0, result},   64'd0);
        check("rst_rd_o",     {59'd0, rd_o},     64'd0);
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Directed cases, issued back-to-back.
        run(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  1'b0);
        run(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  1'b0);
        run(OP_MULHU,  32'h8000_0000,  32'h8000_0000, 5'd7,  1'b0);
        run(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  1'b0);
        run(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  1'b0);
        run(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 1'b0);
        run(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1'b0);
        run(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b0);
        run(OP_DIVU,   32'h1234,       32'd0,         5'd13, 1'b0);
        run(OP_REM,    32'h1234,       32'd0,         5'd14, 1'b0);

        // Flush at cycle 10 of a MUL; DIVU 100/7 issued at cycle 11.
        issue(OP_MUL, 32'd3, 32'd5, 5'd15, 1'b0, c0);
        while (cyc < c0 + 10) @(posedge CLK);
        #1;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        check("flush_busy",     {63'd0, busy},     64'd0);
        check("flush_stallreq", {63'd0, stallreq}, 64'd0);
        check("flush_result",   {32'd0, result},   {32'd0, last_res});
        run(OP_DIVU, 32'd100, 32'd7, 5'd16, 1'b0);

        // Asynchronous reset mid-CALC at cycle 20.
        issue(OP_MUL, 32'h0001_2345, 32'h0000_0777, 5'd17, 1'b0, c0);
        while (cyc < c0 + 20) @(posedge CLK);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("arst_done",     {63'd0, done},     64'd0);
        check("arst_busy",     {63'd0, busy},     64'd0);
        check("arst_stallreq", {63'd0, stallreq}, 64'd0);
        check("arst_result",   {32'd0, result},   64'd0);
        check("arst_rd_o",     {59'd0, rd_o},     64'd0);
        last_res = 32'd0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        run(OP_DIVU, 32'd100, 32'd7, 5'd18, 1'b0);

        // Randomized ops with edge-biased operands.
        for (int i = 0; i < 40; i++) begin
            run(3'($urandom_range(0, 7)), pick(), pick(),
                5'($urandom_range(0, 31)), 1'b1);
        end

        repeat (3) @(posedge CLK);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative RV32M multiply/divide sequencer beside the EX stage. It takes an M-extension operation and two operands from EX and runs a 32-step shift-add multiply or restoring divide over a shared 64-bit accumulator. It holds the pipeline through `stallreq` while busy, and presents the 32-bit result with a one-cycle `done` pulse for EX to write back.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `start` in 1: EX issues an M-extension op this cycle.
- `op` in 3: RV32M funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `src1` in 32: rs1 operand (multiplicand/dividend).
- `src2` in 32: rs2 operand (multiplier/divisor).
- `rd` in 5: destination register tag.
- `flush` in 1: synchronous abort of the operation in flight.
- `stallreq` out 1: pipeline stall request to the stall controller.
- `busy` out 1: sequencer not in IDLE or DONE.
- `done` out 1: one-cycle pulse; `result` and `rd_o` are valid.
- `result` out 32: operation result.
- `rd_o` out 5: destination tag latched at start.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: 32 iterations; `cnt` counts 0..31.
  - FIX: sign correction and result select.
  - DONE: present the result.
- IDLE + `start` + no `flush`:
  - Latch `op` and `rd`.
  - Latch operand magnitudes. A signed operand is negated when its bit 31 = 1. Signedness per op: MULH both; MULHSU src1 only; MULHU neither; DIV/REM both; DIVU/REMU neither; MUL treated as unsigned.
  - Record `neg_res`:
    - mul: sign1 XOR sign2.
    - DIV: sign1 XOR sign2.
    - REM: sign1.
  - Clear the accumulator and `cnt`.
  - If divide op and `src2` == 0: go to DONE directly, with quotient 0xFFFFFFFF and remainder = `src1` (raw).
  - Otherwise go to CALC.
- CALC, multiply: if multiplier LSB = 1, add the multiplicand into the upper accumulator half (33-bit add, carry kept). Then shift {carry, acc} right by 1.
- CALC, divide: shift {rem, quo} left by 1. Trial-subtract the divisor from rem (33-bit). If non-negative, keep the difference and set the quotient LSB.
- CALC exit: after `cnt` == 31, go to FIX.
- FIX:
  - If `neg_res`, apply two's-complement negation: to the 64-bit product for mul, to the quotient or remainder for div.
  - Select the result: MUL = low 32; MULH/MULHSU/MULHU = high 32; DIV/DIVU = quotient; REM/REMU = remainder.
  - Go to DONE.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF needs no special case. The magnitude path yields quotient 0x80000000 and remainder 0.
- DONE:
  - `done` = 1; `result` and `rd_o` are valid.
  - Go to IDLE next edge.
  - `result` and `rd_o` hold until the next operation's FIX/DONE.
- `start` is ignored in CALC, FIX and DONE. EX must not re-issue before observing `done`.
- `flush`:
  - In any state, go to IDLE at the next edge. No `done` pulse; `result` is not updated.
  - `flush` together with `start` in IDLE: `start` is ignored.
- `RST` low: state IDLE immediately; `cnt`, accumulator, `result`, `rd_o`, `done`, `stallreq`, `busy` all 0.

## Timing
- `stallreq` is combinational: (IDLE & `start` & !`flush`) | CALC | FIX. It asserts in the issue cycle so EX holds the instruction.
- `stallreq` = 0 in DONE, so the pipeline advances and EX captures `result` that cycle.
- `busy` = CALC | FIX (registered state decode).
- `done` is a registered pulse, high exactly during DONE.
- Normal latency, with the start cycle as cycle 0:
  - CALC cycles 1–32.
  - FIX cycle 33.
  - DONE (`done` = 1) cycle 34.
  - `stallreq` high cycles 0–33.
- Divide-by-zero latency: `done` in cycle 1; `stallreq` high in cycle 0 only.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE. There is no bubble beyond the DONE cycle.

## Test plan
- MUL: `src1` 7, `src2` 0xFFFFFFFD (−3), `rd` 5 at cycle 0 → `done` at cycle 34, `result` 0xFFFFFFEB, `rd_o` 5, `stallreq` high cycles 0–33.
- MULH / MULHU: both 0x80000000 → MULH `result` 0x40000000; MULHU `result` 0x40000000. MULHSU with `src1` 0xFFFFFFFF, `src2` 2 → 0xFFFFFFFF.
- DIV/REM signs and overflow:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Divide by zero: DIVU 0x1234/0 → `done` at cycle 1, `result` 0xFFFFFFFF. REM 0x1234/0 → 0x1234.
- Flush: MUL started at cycle 0, `flush` at cycle 10 → IDLE at cycle 11, `stallreq` 0, no `done`, `result` unchanged. A new DIVU 100/7 at cycle 11 → `done` at cycle 45, `result` 14.
- Reset: `RST` low mid-CALC (cycle 20), asynchronously → all outputs 0 before the next edge. After release, a start of DIVU 100/7 → correct `result` 14 at cycle 34.
